hazard_scoreboard_unit: RTL

Parametrised hazard unit for the pipelined RISC-V core, sitting beside the ID stage. It replaces the purely combinational load-use/forwarding checker with a register scoreboard that tracks outstanding long-latency writes, such as multi-cycle loads and mul/div. It produces ID-stage stall and operand-forwarding selects, and enforces RAW, WAW and structural (outstanding-capacity) hazards. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: scoreboard of outstanding long-latency writes plus
// load-use detection, operand forwarding selects and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid,
    input  logic [REG_AW-1:0]                  rs1_id,
    input  logic [REG_AW-1:0]                  rs2_id,
    input  logic                               rs1_used,
    input  logic                               rs2_used,
    input  logic [REG_AW-1:0]                  rd_id,
    input  logic                               reg_write_id,
    input  logic                               long_lat_id,
    input  logic                               flush,
    input  logic [REG_AW-1:0]                  rd_ex,
    input  logic [REG_AW-1:0]                  rd_mem,
    input  logic                               reg_write_ex,
    input  logic                               reg_write_mem,
    input  logic                               mem_read_ex,
    input  logic                               cpl_valid,
    input  logic [REG_AW-1:0]                  cpl_rd,
    output logic                               stall_out,
    output logic [1:0]                         forward_a,
    output logic [1:0]                         forward_b,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic [CNT_W-1:0]                   stall_cycles,
    output logic                               cpl_err
);

    localparam int PCW = $clog2(MAX_PENDING + 1);
    localparam logic [PCW-1:0] MAX_CNT = PCW'(MAX_PENDING);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic load_use, raw, waw, structural;
    logic issue, set_en, clr_en, err_en;

    // Addresses beyond NUM_REGS read as not pending.
    function automatic logic pend_at(input logic [REG_AW-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r == REG_AW'(i)) hit = pending[i];
        return hit;
    endfunction

    function automatic logic cpl_hit(input logic [REG_AW-1:0] r);
        return cpl_valid && (cpl_rd == r) && (r != '0);
    endfunction

    function automatic logic eff_pending(input logic [REG_AW-1:0] r);
        return pend_at(r) && !cpl_hit(r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && rs != '0) begin
            if (reg_write_ex && rd_ex == rs)        sel = 2'b10;
            else if (reg_write_mem && rd_mem == rs) sel = 2'b01;
            else if (cpl_hit(rs))                   sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        load_use   = 1'b0;
        raw        = 1'b0;
        waw        = 1'b0;
        structural = 1'b0;
        if (id_valid) begin
            load_use   = mem_read_ex && reg_write_ex && (rd_ex != '0) &&
                         ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
            raw        = (rs1_used && eff_pending(rs1_id)) || (rs2_used && eff_pending(rs2_id));
            waw        = reg_write_id && long_lat_id && (rd_id != '0) && eff_pending(rd_id);
            structural = long_lat_id && reg_write_id && (pending_count == MAX_CNT) && !cpl_valid;
        end
        stall_out = load_use || raw || waw || structural;
        forward_a = fwd_sel(rs1_id, rs1_used);
        forward_b = fwd_sel(rs2_id, rs2_used);
    end

    always_comb begin
        issue  = id_valid && !stall_out && !flush;
        set_en = issue && long_lat_id && reg_write_id && (rd_id != '0);
        clr_en = cpl_valid && (cpl_rd != '0) && pend_at(cpl_rd);
        err_en = cpl_valid && (cpl_rd != '0) && !pend_at(cpl_rd);
        pending_nxt = pending;
        // Set is applied after clear so a same-register set/clear leaves the bit at 1.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_en && cpl_rd == REG_AW'(i)) pending_nxt[i] = 1'b0;
            if (set_en && rd_id == REG_AW'(i))  pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            pending_count <= '0;
            stall_cycles  <= '0;
            cpl_err       <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (set_en && !clr_en)
                pending_count <= pending_count + 1'b1;
            else if (clr_en && !set_en)
                pending_count <= pending_count - 1'b1;
            if (stall_out && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (err_en)
                cpl_err <= 1'b1;
        end
    end

endmodule
